usr_seq: RTL

Parametrised universal shift register with per-cycle shift, rotate, arithmetic-shift and parallel-load modes, plus a counted burst-shift sequencer with a busy/done handshake. It is the general-purpose serial/parallel conversion stage for the protocol datapaths. It supports arbitrary word width and multi-position shifts without host cycle-by-cycle control.

---
 rtl/usr_pkg.sv | 21 ++
 rtl/usr_seq_if.sv | 35 +++
 rtl/usr_burst_ctrl.sv | 84 ++++++++
 rtl/usr_seq.sv | 84 ++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg -- shared definitions for the usr_seq universal shift register.
//   SEL_*        : per-cycle mode encodings carried on the 3-bit select input
//   seq_state_e  : burst sequencer state (IDLE / SHIFT / DONE)
package usr_pkg;

   localparam logic [2:0] SEL_HOLD = 3'b000;
   localparam logic [2:0] SEL_SHR  = 3'b001;
   localparam logic [2:0] SEL_SHL  = 3'b010;
   localparam logic [2:0] SEL_LOAD = 3'b011;
   localparam logic [2:0] SEL_ROR  = 3'b100;
   localparam logic [2:0] SEL_ROL  = 3'b101;
   localparam logic [2:0] SEL_ASR  = 3'b110;
   localparam logic [2:0] SEL_RSV  = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/usr_seq_if.sv
// usr_seq_if -- control/data bundle of the usr_seq shift register.
//   master : drives en, select, data_in, MSB_in, LSB_in, start, count, dir
//            and observes data_out, MSB_out, LSB_out, busy, done, sel_err
//   slave  : the register itself (directions reversed)
// Clock and reset are kept as plain ports on the module, not in here.
interface usr_seq_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [2:0]       select;
   logic [WIDTH-1:0] data_in;
   logic             MSB_in;
   logic             LSB_in;
   logic             start;
   logic [CW-1:0]    count;
   logic             dir;
   logic [WIDTH-1:0] data_out;
   logic             MSB_out;
   logic             LSB_out;
   logic             busy;
   logic             done;
   logic             sel_err;

   modport master (
      output en, select, data_in, MSB_in, LSB_in, start, count, dir,
      input  data_out, MSB_out, LSB_out, busy, done, sel_err
   );

   modport slave (
      input  en, select, data_in, MSB_in, LSB_in, start, count, dir,
      output data_out, MSB_out, LSB_out, busy, done, sel_err
   );
endinterface

// File: rtl/usr_burst_ctrl.sv
// usr_burst_ctrl -- counted burst-shift sequencer for usr_seq.
//   CLK, clear  : clock, synchronous active-low reset
//   start       : burst request, honoured only in IDLE
//   count, dir  : shift count (clamped to WIDTH) and direction (1 = left)
//   busy, done  : SHIFT-state and DONE-state indicators
//   idle        : sequencer in IDLE, select operations may run
//   start_acc   : a start is being accepted this cycle
//   shift_en    : perform one burst shift on this edge
//   shift_left  : direction latched at start
module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          CLK,
   input  logic          clear,
   input  logic          start,
   input  logic [CW-1:0] count,
   input  logic          dir,
   output logic          busy,
   output logic          done,
   output logic          idle,
   output logic          start_acc,
   output logic          shift_en,
   output logic          shift_left
);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic [CW-1:0] count_clamped;

   assign count_clamped = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      start_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               dir_d     = dir;
               if (count_clamped == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
                  cnt_d   = count_clamped;
               end
            end
         end
         SHIFT: begin
            // cnt_q counts shifts still to do, including this edge's one
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   assign busy       = (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign idle       = (state_q == IDLE);
   assign shift_en   = busy;
   assign shift_left = dir_q;

endmodule

// File: rtl/usr_seq.sv
// usr_seq -- universal shift register with counted burst shifts.
//   CLK   : clock, all state changes on the rising edge
//   clear : synchronous active-low reset
//   bus   : usr_seq_if.slave -- mode/select inputs, parallel and serial data,
//           burst request (start/count/dir) and the data/busy/done/sel_err outputs
// Build option: define USR_ROTATE_EN to implement select 100/101 as rotates;
// without it those encodings hold and raise sel_err like the reserved code.
module usr_seq
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic     CLK,
   input  logic     clear,
   usr_seq_if.slave bus
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_err_q, sel_err_d;
   logic             busy, done, idle, start_acc, shift_en, shift_left;

   usr_burst_ctrl #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_ctrl (
      .CLK        (CLK),
      .clear      (clear),
      .start      (bus.start),
      .count      (bus.count),
      .dir        (bus.dir),
      .busy       (busy),
      .done       (done),
      .idle       (idle),
      .start_acc  (start_acc),
      .shift_en   (shift_en),
      .shift_left (shift_left)
   );

   // Burst shifts outrank everything; an accepted start swallows the select
   // operation (and any sel_err) of the same cycle.
   always_comb begin
      data_d    = data_q;
      sel_err_d = 1'b0;
      if (shift_en) begin
         if (shift_left) data_d = {data_q[WIDTH-2:0], bus.LSB_in};
         else            data_d = {bus.MSB_in, data_q[WIDTH-1:1]};
      end else if (idle && !start_acc && bus.en) begin
         case (bus.select)
            SEL_HOLD: data_d = data_q;
            SEL_SHR:  data_d = {bus.MSB_in, data_q[WIDTH-1:1]};
            SEL_SHL:  data_d = {data_q[WIDTH-2:0], bus.LSB_in};
            SEL_LOAD: data_d = bus.data_in;
`ifdef USR_ROTATE_EN
            SEL_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
            SEL_ROL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`else
            SEL_ROR,
            SEL_ROL:  sel_err_d = 1'b1;
`endif
            SEL_ASR:  data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            default:  sel_err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!clear) begin
         data_q    <= '0;
         sel_err_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign bus.data_out = data_q;
   assign bus.MSB_out  = data_q[WIDTH-1];
   assign bus.LSB_out  = data_q[0];
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.sel_err  = sel_err_q;

endmodule
